// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between EX-stage decode and the M-extension sequencer.
interface muldiv_sequencer_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, kill, input busy, stall, done, result);
  modport slave  (input start, op, a, b, kill, output busy, stall, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply/divide sequencer: shift-add multiply and restoring
// divide, one bit per cycle, followed by a sign fix-up cycle.
// Optional macro MULDIV_ZERO_BYPASS_EN: multiplies with a zero operand finish
// in one cycle with a zero result.
module muldiv_sequencer #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input logic              clk,
  input logic              reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // MUL: {accumulated high, remaining multiplier}; DIV: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] prod_q, prod_d;
  // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_neg, b_neg, b_zero;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  // Operand conditioning: sign flags and magnitudes of the incoming request
  always_comb begin
    a_neg  = bus.a[XLEN-1] & ((bus.op == 3'b001) | (bus.op == 3'b010) |
                              (bus.op == 3'b100) | (bus.op == 3'b110));
    b_neg  = bus.b[XLEN-1] & ((bus.op == 3'b001) | (bus.op == 3'b100) |
                              (bus.op == 3'b110));
    b_zero = (bus.b == '0);
    mag_a  = a_neg ? (~bus.a + 1'b1) : bus.a;
    mag_b  = b_neg ? (~bus.b + 1'b1) : bus.b;
  end

  // Datapath: one multiply step, one restoring-divide step, and the sign fix-up
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
    div_trial = prod_q[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, opnd_q};
    div_ge    = (div_trial >= {1'b0, opnd_q});
    div_rem   = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
    prod_fix  = (sign_a_q ^ sign_b_q) ? (~prod_q + 1'b1) : prod_q;
    quot_fix  = (sign_a_q ^ sign_b_q) ? (~prod_q[XLEN-1:0] + 1'b1) : prod_q[XLEN-1:0];
    rem_fix   = sign_a_q ? (~prod_q[2*XLEN-1:XLEN] + 1'b1) : prod_q[2*XLEN-1:XLEN];
    unique case (op_q)
      3'b000:                 fix_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = quot_fix;
      default:                fix_val = rem_fix;
    endcase
  end

  // Next-state and register-load logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    op_d     = op_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          cnt_d    = '0;
          if (!bus.op[2]) begin
            opnd_d  = mag_a;
            prod_d  = {{XLEN{1'b0}}, mag_b};
            state_d = S_MUL;
`ifdef MULDIV_ZERO_BYPASS_EN
            if ((bus.a == '0) || (bus.b == '0)) begin
              result_d = '0;
              state_d  = S_DONE;
            end
`endif
          end else if (b_zero) begin
            // Preload quotient = all ones, remainder = |a|. Matching the divisor
            // sign to the dividend keeps the quotient un-negated while the
            // remainder still regains a's sign, so the fix-up yields a exactly.
            opnd_d   = mag_b;
            prod_d   = {mag_a, {XLEN{1'b1}}};
            sign_b_d = a_neg;
            state_d  = S_FIX;
          end else begin
            opnd_d  = mag_b;
            prod_d  = {{XLEN{1'b0}}, mag_a};
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        prod_d = {mul_sum, prod_q[XLEN-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        prod_d = {div_rem, prod_q[XLEN-2:0], div_ge};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    bus.busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    bus.stall  = bus.busy || (bus.start && (state_q == S_IDLE));
    bus.done   = (state_q == S_DONE);
    bus.result = result_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (XLEN = 64) with hand-computed results.
module tb_muldiv_sequencer;

  localparam logic [63:0] ONES = '1;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  muldiv_sequencer_if #(.XLEN(64)) bus ();

  muldiv_sequencer #(.XLEN(64), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; that cycle is cycle 0 of the request.
  task automatic do_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                       output int done_cyc, output int busy_n, output int stall_n);
    int cyc;
    bit seen;
    bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
    busy_n = 0; stall_n = 0; done_cyc = -1; seen = 0;
    @(negedge clk);
    busy_n += int'(bus.busy); stall_n += int'(bus.stall);
    @(posedge clk); #1; bus.start = 1'b0;
    cyc = 1;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      busy_n += int'(bus.busy); stall_n += int'(bus.stall);
      if (bus.done) begin
        seen = 1; done_cyc = cyc;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [63:0] x,
                     input logic [63:0] y, input int exp_cyc, input logic [63:0] exp_res);
    int dc, bn, sn;
    do_op(o, x, y, dc, bn, sn);
    check({tag, "_cyc"}, 64'(dc), 64'(exp_cyc));
    check({tag, "_res"}, bus.result, exp_res);
  endtask

  initial begin
    int dc, bn, sn, cyc, pulses, d1, d2;
    logic [63:0] r1, r2;
    reset = 1'b1; bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", bus.result, 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;

    do_op(3'b000, 64'd7, -64'sd3, dc, bn, sn);
    check("mul_cyc", 64'(dc), 64'd66);
    check("mul_res", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul_busy_cycles", 64'(bn), 64'd65);
    check("mul_stall_cycles", 64'(sn), 64'd66);

    run("mulhu_ones",  3'b011, ONES, ONES, 66, 64'hFFFF_FFFF_FFFF_FFFE);
    run("mulh_ones",   3'b001, ONES, ONES, 66, 64'd0);
    run("mulhsu_m1x2", 3'b010, ONES, 64'd2, 66, ONES);
    run("div_m7_2",    3'b100, -64'sd7, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFD);
    run("rem_m7_2",    3'b110, -64'sd7, 64'd2, 66, ONES);
    run("divu_100_7",  3'b101, 64'd100, 64'd7, 66, 64'd14);
    run("remu_100_7",  3'b111, 64'd100, 64'd7, 66, 64'd2);

    do_op(3'b100, 64'd5, 64'd0, dc, bn, sn);
    check("div0_cyc", 64'(dc), 64'd2);
    check("div0_res", bus.result, ONES);
    check("div0_busy_cycles", 64'(bn), 64'd1);
    check("div0_stall_cycles", 64'(sn), 64'd2);
    run("rem0_5",      3'b110, 64'd5, 64'd0, 2, 64'd5);
    run("div0_m5",     3'b100, -64'sd5, 64'd0, 2, ONES);
    run("rem0_m5",     3'b110, -64'sd5, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFB);
    run("divu0_5",     3'b101, 64'd5, 64'd0, 2, ONES);
    run("div_ovf",     3'b100, MIN, ONES, 66, MIN);
    run("rem_ovf",     3'b110, MIN, ONES, 66, 64'd0);
    run("mul_big",     3'b000, 64'h1_0000_0001, 64'h1_0000_0001, 66, 64'h0000_0002_0000_0001);
    run("mulhu_big",   3'b011, 64'h1_0000_0001, 64'h1_0000_0001, 66, 64'd1);

    // Kill in cycle 30 of a multiply: idle in cycle 31, no done, result kept.
    bus.op = 3'b000; bus.a = 64'd11; bus.b = 64'd13; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    cyc = 1; pulses = 0;
    while (cyc < 31) begin
      if (cyc == 30) bus.kill = 1'b1;
      @(negedge clk);
      if (bus.done) pulses++;
      @(posedge clk); #1; cyc++;
    end
    bus.kill = 1'b0;
    check("kill_busy", 64'(bus.busy), 64'd0);
    check("kill_done", 64'(bus.done), 64'd0);
    check("kill_pulses", 64'(pulses), 64'd0);
    check("kill_result", bus.result, 64'd1);
    run("after_kill",  3'b000, 64'd11, 64'd13, 66, 64'd143);

    // Kill and start together in IDLE: kill wins.
    bus.op = 3'b000; bus.a = 64'd2; bus.b = 64'd2; bus.start = 1'b1; bus.kill = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.kill = 1'b0;
    check("kill_prio_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("kill_prio_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;

`ifdef MULDIV_ZERO_BYPASS_EN
    run("mul_zero",    3'b000, 64'd0, 64'd9, 1, 64'd0);
`else
    run("mul_zero",    3'b000, 64'd0, 64'd9, 66, 64'd0);
`endif

    // Start held high across DONE; operands changed while busy.
    bus.op = 3'b000; bus.a = 64'd3; bus.b = 64'd5; bus.start = 1'b1;
    cyc = 0; pulses = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    while (cyc <= 140) begin
      if (cyc == 10) begin bus.a = 64'd6; bus.b = 64'd7; end
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (d1 < 0) begin d1 = cyc; r1 = bus.result; end
        else begin d2 = cyc; r2 = bus.result; end
      end
      @(posedge clk); #1; cyc++;
      if (cyc == 68) bus.start = 1'b0;
    end
    check("hold_pulses", 64'(pulses), 64'd2);
    check("hold_d1_cyc", 64'(d1), 64'd66);
    check("hold_r1", r1, 64'd15);
    check("hold_d2_cyc", 64'(d2), 64'd133);
    check("hold_r2", r2, 64'd42);

    // Asynchronous reset in the middle of a divide.
    bus.op = 3'b101; bus.a = 64'd100; bus.b = 64'd7; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (39) @(posedge clk);
    #3; reset = 1'b1; #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_result", bus.result, 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    run("after_rst",   3'b101, 64'd100, 64'd7, 66, 64'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV64M multiply/divide instructions.
- Runs an iterative shift-add multiply or restoring divide over XLEN cycles.
- Sits beside the main ALU in the EX stage. Holds the pipeline via `stall` while an M-extension op is in flight.
- Decode asserts `start` when opcode is OP/OP-32 with funct7 = 0000001; `op` = funct3.

Parameters:
- XLEN, 64, operand/result width; must be even and ≥ 8.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand; sampled with start.
- b  input  XLEN  rs2 operand; sampled with start.
- kill  input  1  pipeline flush; aborts the op in flight.
- busy  output  1  high when state ≠ IDLE and state ≠ DONE.
- stall  output  1  = busy | (start & state==IDLE); combinational.
- done  output  1  one-cycle pulse, result valid.
- result  output  XLEN  registered result; holds until the next done.

Behaviour:
- Reset (async, active-high): state = IDLE; busy = 0, done = 0, result = 0. Counter and internal registers = 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, on start:
  - Latch the operand magnitudes and sign flags:
    - Signed: a for MULH, MULHSU, DIV, REM; b for MULH, DIV, REM.
    - Unsigned: all other cases.
  - Clear the counter.
  - op[2] = 0 → MUL; op[2] = 1 → DIV.
- MUL: 2·XLEN-bit product register, one shift-add step per cycle. After XLEN steps → FIX.
- DIV: restoring algorithm, one quotient bit per cycle. After XLEN steps → FIX.
- FIX:
  - Apply sign correction:
    - Product: negated if the operand signs differ.
    - Quotient: negated if the signs differ.
    - Remainder: takes the dividend's sign.
  - Select the output:
    - MUL: low half of the product.
    - MULH/MULHSU/MULHU: high half of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Load `result`; → DONE.
- DONE: done = 1 for exactly one cycle → IDLE. A start in DONE is ignored; the requester re-presents it in the next cycle.
- Latency: start accepted at edge E0; done high in the cycle after edge E(XLEN+1), i.e. XLEN+2 cycles after the start cycle.
- Divide by zero (b == 0), detected in IDLE:
  - Skip DIV and go straight to FIX.
  - Quotient = all ones; remainder = a.
  - Latency = 2 cycles.
- Signed overflow (DIV/REM, a = 100…0, b = all ones): quotient = 100…0, remainder = 0. The result must fall out of the normal iteration and sign fixup; no special path is added.
- kill:
  - Any state → IDLE on the next edge; no done.
  - `result` keeps its old value.
  - kill has priority over start in the same cycle.
- start while busy: ignored; the operands in flight are unaffected.
- Reset mid-operation: immediate return to the reset values; no done.

Optional Feature:
- Macro MULDIV_ZERO_BYPASS_EN.
- Defined: in IDLE, if a == 0 or b == 0 for a MUL-class op (op[2] = 0), go directly to DONE with result = 0. Latency = 1 cycle (done in the cycle after start).
- Undefined: zero operands take the full XLEN+2 path. The divide-by-zero shortcut exists regardless of the macro.

Test Plan:
- MUL a=7, b=−3 → done at cycle 66, result = 0xFFFF_FFFF_FFFF_FFEB; busy high cycles 1–65, stall high cycles 0–65.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → result = 0xFFFF_FFFF_FFFF_FFFE. Same operands with MULH → result = 0.
- DIV a=−7, b=2 → result = −3. REM with the same operands → result = −1. DIVU a=100, b=7 → 14; REMU → 2.
- DIV a=5, b=0 → done at cycle 2, result = all ones. REM a=5, b=0 → 5. DIV a=0x8000_0000_0000_0000, b=−1 → result = 0x8000_0000_0000_0000; REM → 0.
- Kill and start interplay:
  - Start MUL; kill at cycle 30 → state IDLE at cycle 31, no done pulse, result unchanged.
  - Start again in cycle 31 → completes normally.
  - Start held high through DONE is ignored until IDLE.
- Reset asserted asynchronously mid-DIV (cycle 40) → busy/done/result = 0 immediately. With MULDIV_ZERO_BYPASS_EN defined: MUL a=0, b=9 → done at cycle 1, result = 0.
